// File: rtl/dma_arbiter_pkg.sv
// Shared constants and types for dma_arbiter.
// DMC_DMA_EN adds the DMC fetch states.
package dma_arbiter_pkg;

  localparam logic [15:0] OAM_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
  localparam int          OAM_LEN       = 256;
  localparam logic [7:0]  OAM_LAST      = 8'(OAM_LEN - 1);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HALT    = 3'd1;
  localparam state_t ST_ALIGN   = 3'd2;
  localparam state_t ST_OAM_GET = 3'd3;
  localparam state_t ST_OAM_PUT = 3'd4;
`ifdef DMC_DMA_EN
  localparam state_t ST_DMC_GET = 3'd5;
  localparam state_t ST_DMC_ACK = 3'd6;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
  } bus_t;

  function automatic logic [15:0] oam_addr(
    input logic [7:0] page,
    input logic [7:0] idx
  );
    return {page, idx};
  endfunction

endpackage

// File: rtl/dma_arbiter.sv
// OAM/DMC DMA arbiter sharing the CPU bus on get/put parity.
// Define DMC_DMA_EN to build the DMC sample-fetch path.
module dma_arbiter
  import dma_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_rw_i,
  input  logic        rdy_i,
  output logic        cpu_rdy_o,
  input  logic [7:0]  bus_data_i,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_rw_o,
  input  logic        dmc_req_i,
  input  logic [15:0] dmc_addr_i,
  output logic        dmc_ack_o,
  output logic [7:0]  dmc_data_o,
  output logic        oam_busy_o
);

  state_t     state_q, state_d, slot_nxt;
  logic       par_q;
  logic       busy_q, busy_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic       trig, dmc_ok, oam_want;
  bus_t       bus;

`ifdef DMC_DMA_EN
  // The request is still high during its own ack cycle; don't refetch.
  assign dmc_ok = dmc_req_i && (state_q != ST_DMC_ACK);
`else
  logic unused_dmc;
  assign unused_dmc = ^{dmc_req_i, dmc_addr_i};
  assign dmc_ok     = 1'b0;
`endif

  assign trig = (state_q == ST_IDLE) && rdy_i && !cpu_rw_i
             && (cpu_addr_i == OAM_TRIG_ADDR) && !busy_q;

  assign oam_want = busy_q
                 && !((state_q == ST_OAM_PUT) && (idx_q == OAM_LAST));

  // par_q=1 now means the next cycle is a get slot.
  always_comb begin
    slot_nxt = ST_IDLE;
    if (par_q) begin
      if (oam_want) slot_nxt = ST_OAM_GET;
`ifdef DMC_DMA_EN
      if (dmc_ok) slot_nxt = ST_DMC_GET;
`endif
    end else begin
      if (dmc_ok || oam_want) slot_nxt = ST_ALIGN;
      if (state_q == ST_OAM_GET) slot_nxt = ST_OAM_PUT;
`ifdef DMC_DMA_EN
      if (state_q == ST_DMC_GET) slot_nxt = ST_DMC_ACK;
`endif
    end
  end

  always_comb begin
    state_d = slot_nxt;
    busy_d  = busy_q;
    page_d  = page_q;
    idx_d   = idx_q;
    if (state_q == ST_IDLE) begin
      state_d = ((busy_q || dmc_ok) && cpu_rw_i) ? ST_HALT : ST_IDLE;
      if (trig) begin
        page_d = cpu_data_i;
        idx_d  = '0;
        busy_d = 1'b1;
      end
    end
    if (state_q == ST_OAM_PUT) begin
      idx_d = idx_q + 8'd1;
      if (idx_q == OAM_LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
      page_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      par_q   <= ~par_q;
      busy_q  <= busy_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    bus        = '{addr: cpu_addr_i, data: cpu_data_i, rw: 1'b1};
    cpu_rdy_o  = 1'b0;
    dmc_ack_o  = 1'b0;
    dmc_data_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        bus.rw    = cpu_rw_i;
        cpu_rdy_o = rdy_i;
      end
      ST_OAM_GET: bus.addr = oam_addr(page_q, idx_q);
      ST_OAM_PUT: begin
        bus = '{addr: OAM_DATA_ADDR, data: bus_data_i, rw: 1'b0};
      end
`ifdef DMC_DMA_EN
      ST_DMC_GET: bus.addr = dmc_addr_i;
      ST_DMC_ACK: begin
        dmc_ack_o  = 1'b1;
        dmc_data_o = bus_data_i;
      end
`endif
      default: ;
    endcase
  end

  assign bus_addr_o = bus.addr;
  assign bus_data_o = bus.data;
  assign bus_rw_o   = bus.rw | ~rst_n;
  assign oam_busy_o = busy_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Self-checking bench for dma_arbiter: vector table,
// directed DMA sequences and randomized OAM/DMC mixes.
`timescale 1ns/1ps
module tb_dma_arbiter;
  import dma_arbiter_pkg::*;

`ifdef DMC_DMA_EN
  localparam int DMC_EN = 1;
`else
  localparam int DMC_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cpu_addr_i = '0;
  logic [7:0]  cpu_data_i = '0;
  logic        cpu_rw_i = 1'b1;
  logic        rdy_i = 1'b1;
  logic        cpu_rdy_o;
  logic [7:0]  bus_data_i = '0;
  logic [15:0] bus_addr_o;
  logic [7:0]  bus_data_o;
  logic        bus_rw_o;
  logic        dmc_req_i = 1'b0;
  logic [15:0] dmc_addr_i = '0;
  logic        dmc_ack_o;
  logic [7:0]  dmc_data_o;
  logic        oam_busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  dma_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_rw_i(cpu_rw_i), .rdy_i(rdy_i), .cpu_rdy_o(cpu_rdy_o),
    .bus_data_i(bus_data_i), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o), .bus_rw_o(bus_rw_o),
    .dmc_req_i(dmc_req_i), .dmc_addr_i(dmc_addr_i),
    .dmc_ack_o(dmc_ack_o), .dmc_data_o(dmc_data_o),
    .oam_busy_o(oam_busy_o)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Bus memory: returns the byte for last cycle's address.
  initial begin
    logic [15:0] pa;
    forever begin
      @(negedge clk);
      #2 pa = bus_addr_o;
      @(posedge clk);
      #1 bus_data_i = mem(pa);
    end
  end

  // Parity of the current cycle is cyc % 2.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) cyc = 0;
    else cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cpu(input logic [15:0] a, input logic [7:0] d,
                     input logic rw);
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_rw_i   = rw;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    logic        rdy;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        erw;
    logic        erdy;
  } vec_t;

  task automatic run_oam(input logic [7:0] page, input int want_par,
                         input int extra_wr, input int dmc_at,
                         input logic [15:0] daddr);
    int halted, nw, acks, ack_nw, bad, rpar, hp, expc;
    logic [7:0] ackd;
    bit started, raised;
    halted = 0; nw = 0; acks = 0; ack_nw = -1; bad = 0;
    rpar = -1; ackd = '0; started = 0; raised = 0;
    dmc_addr_i = daddr;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cyc % 2 == want_par) break;
      cpu(16'h8000, 8'h00, 1'b1);
    end
    cpu(OAM_TRIG_ADDR, page, 1'b0);
    if (dmc_at == 0) begin
      dmc_req_i = 1'b1;
      raised = 1;
    end
    if (extra_wr != 0) begin
      @(negedge clk);
      cpu(OAM_TRIG_ADDR, page ^ 8'hFF, 1'b0);
    end
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      cpu(16'h8123, 8'h00, 1'b1);
      if (rpar < 0) rpar = cyc % 2;
      #1;
      if (!cpu_rdy_o) begin
        halted++;
        started = 1;
      end else if (started) break;
      if (!bus_rw_o) begin
        if (bus_addr_o !== OAM_DATA_ADDR ||
            bus_data_o !== mem({page, nw[7:0]})) bad++;
        nw++;
      end
      if (dmc_ack_o) begin
        acks++;
        ackd = dmc_data_o;
        ack_nw = nw;
        dmc_req_i = 1'b0;
      end
      if (dmc_at > 0 && !raised && nw == dmc_at) begin
        dmc_req_i = 1'b1;
        raised = 1;
      end
    end
    dmc_req_i = 1'b0;
    hp = (rpar ^ 1) & 1;
    expc = 513 + ((hp == 0) ? 1 : 0) + ((dmc_at >= 0) ? 2 * DMC_EN : 0);
    chk("oam_halted", halted, expc);
    chk("oam_writes", nw, 256);
    chk("oam_data_bad", bad, 0);
    chk("oam_busy_end", {31'd0, oam_busy_o}, 0);
    if (dmc_at >= 0) begin
      chk("dmc_acks", acks, DMC_EN);
      chk("dmc_data", {24'd0, ackd}, DMC_EN * mem(daddr));
      chk("dmc_slot", ack_nw, (DMC_EN != 0) ? dmc_at : -1);
    end
  endtask

  task automatic run_dmc(input logic [15:0] daddr, input int nwr,
                         input int cancel);
    int halted, acks, wr_halt, rpar, hp, expc;
    logic [7:0] ackd;
    halted = 0; acks = 0; wr_halt = 0; ackd = '0;
    dmc_addr_i = daddr;
    for (int i = 0; i < nwr; i++) begin
      @(negedge clk);
      cpu(16'h0300 + 16'(i), 8'(i), 1'b0);
      dmc_req_i = 1'b1;
      #1 if (!cpu_rdy_o) wr_halt++;
    end
    @(negedge clk);
    cpu(16'h8200, 8'h00, 1'b1);
    dmc_req_i = 1'b1;
    rpar = cyc % 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cpu(16'h8200, 8'h00, 1'b1);
      if (cancel != 0) dmc_req_i = 1'b0;
      #1;
      if (!cpu_rdy_o) halted++;
      if (dmc_ack_o) begin
        acks++;
        ackd = dmc_data_o;
        dmc_req_i = 1'b0;
      end
    end
    dmc_req_i = 1'b0;
    chk("dmc_write_halt", wr_halt, 0);
    if (cancel != 0) begin
      chk("dmc_cancel_ack", acks, 0);
      chk("dmc_cancel_short", {31'd0, halted <= 1}, 1);
    end else begin
      hp = (rpar ^ 1) & 1;
      expc = DMC_EN * ((hp == 0) ? 4 : 3);
      chk("dmc_halted", halted, expc);
      chk("dmc_acks", acks, DMC_EN);
      chk("dmc_data", {24'd0, ackd}, DMC_EN * mem(daddr));
    end
  endtask

  task automatic run_reset_mid();
    int nw, wr, halted;
    nw = 0; wr = 0; halted = 0;
    @(negedge clk);
    cpu(OAM_TRIG_ADDR, 8'h07, 1'b0);
    for (int i = 0; i < 800 && nw < 128; i++) begin
      @(negedge clk);
      cpu(16'h8123, 8'h00, 1'b1);
      #1 if (!bus_rw_o) nw++;
    end
    chk("rst_reached_idx", nw, 128);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, oam_busy_o}, 0);
    chk("rst_mid_rdy", {31'd0, cpu_rdy_o}, 1);
    chk("rst_mid_rw", {31'd0, bus_rw_o}, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      cpu(16'h8123, 8'h00, 1'b1);
      #1;
      if (!bus_rw_o) wr++;
      if (!cpu_rdy_o) halted++;
    end
    chk("rst_no_write", wr, 0);
    chk("rst_no_halt", halted, 0);
  endtask

  initial begin
    vec_t tv[4];
    tv[0] = '{16'h1234, 8'hAB, 1'b1, 1'b1, 16'h1234, 8'hAB, 1'b1, 1'b1};
    tv[1] = '{16'h4015, 8'h55, 1'b0, 1'b1, 16'h4015, 8'h55, 1'b0, 1'b1};
    tv[2] = '{16'hFFFC, 8'h00, 1'b1, 1'b0, 16'hFFFC, 8'h00, 1'b1, 1'b0};
    tv[3] = '{16'h4013, 8'h02, 1'b0, 1'b0, 16'h4013, 8'h02, 1'b0, 1'b0};

    #1 rst_n = 1'b0;
    cpu(16'h4015, 8'h99, 1'b0);
    dmc_req_i = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rdy", {31'd0, cpu_rdy_o}, 1);
    chk("rst_rw", {31'd0, bus_rw_o}, 1);
    chk("rst_ack", {31'd0, dmc_ack_o}, 0);
    chk("rst_dmc_data", {24'd0, dmc_data_o}, 0);
    chk("rst_busy", {31'd0, oam_busy_o}, 0);
    rdy_i = 1'b0;
    #1 chk("rst_rdy_follow", {31'd0, cpu_rdy_o}, 0);
    rdy_i = 1'b1;
    dmc_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      cpu(tv[i].a, tv[i].d, tv[i].rw);
      rdy_i = tv[i].rdy;
      #1;
      chk("vec_addr", {16'd0, bus_addr_o}, {16'd0, tv[i].ea});
      chk("vec_data", {24'd0, bus_data_o}, {24'd0, tv[i].ed});
      chk("vec_rw", {31'd0, bus_rw_o}, {31'd0, tv[i].erw});
      chk("vec_rdy", {31'd0, cpu_rdy_o}, {31'd0, tv[i].erdy});
    end
    rdy_i = 1'b1;

    run_oam(8'h02, 0, 0, -1, 16'h0000);
    run_oam(8'h02, 1, 0, -1, 16'h0000);
    run_oam(8'h33, 0, 0, 8'h40, 16'hC000);
    run_oam(8'h11, 1, 0, 0, 16'hC100);
    run_oam(8'h05, 0, 1, -1, 16'h0000);
    run_dmc(16'hC000, 0, 0);
    run_dmc(16'hC000, 3, 0);
    run_dmc(16'hC0F0, 1, 0);
    run_dmc(16'hC200, 0, 1);

    for (int k = 0; k < 8; k++) begin
      int da;
      da = ($urandom % 3 == 0) ? -1 : int'($urandom_range(0, 255));
      run_oam(8'($urandom), int'($urandom % 2), int'($urandom % 2),
              da, 16'($urandom));
    end

    run_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
